// File: rtl/pin_ctrl_axil_slave.sv
// pin_ctrl_axil_slave
//   AXI4-Lite responder for the GPIO pin-control register bank.
//
//   Register map (byte address bits [3:2]):
//     0x0 PIN_OUT  R/W   drives pin_o
//     0x4 PIN_OE   R/W   drives pin_oe (1 = drive pad)
//     0x8 PIN_IN   RO    2-flop synchronized pin_i; writes return SLVERR
//     0xC SCRATCH  R/W   general purpose
//
//   Ports:
//     S_AXI_ACLK / S_AXI_ARESET   clock, synchronous active-high reset
//     S_AXI_AW* / W* / B*         AXI4-Lite write address, data, response
//     S_AXI_AR* / R*              AXI4-Lite read address, data
//     pin_i                       asynchronous pad inputs
//     pin_o / pin_oe              registered pad outputs / output enables
//
//   Write FSM
//     state       | meaning
//     W_IDLE      | ready for AW and W
//     W_HAVE_ADDR | address latched, waiting for W
//     W_HAVE_DATA | data/strobe latched, waiting for AW
//     W_RESP      | write committed, BVALID held until BREADY
//
//   Read FSM
//     state       | meaning
//     R_IDLE      | ready for AR
//     R_DATA      | RDATA valid, held until RREADY

module pin_ctrl_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          NUM_PINS           = 32,
  parameter logic [31:0] PIN_OUT_RESET      = 32'h0
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [NUM_PINS-1:0]               pin_i,
  output logic [NUM_PINS-1:0]               pin_o,
  output logic [NUM_PINS-1:0]               pin_oe
);

  // Bits at and above NUM_PINS are never stored and always read back as 0.
  localparam logic [31:0] PIN_MASK = 32'hFFFF_FFFF >> (32 - NUM_PINS);

  localparam logic [1:0] A_OUT = 2'd0;
  localparam logic [1:0] A_OE  = 2'd1;
  localparam logic [1:0] A_IN  = 2'd2;
  localparam logic [1:0] A_SCR = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t      w_state;
  r_state_t      r_state;

  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp;
  logic [31:0]   rdata;

  logic [1:0]    wr_addr_q;
  logic [31:0]   wr_data_q;
  logic [3:0]    wr_strb_q;

  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;

  logic [31:0]   reg_out, reg_oe, reg_scr;
  logic [NUM_PINS-1:0] sync1, sync2;
  logic [31:0]   pin_in_ext;
  logic [31:0]   rd_mux;

  logic          aw_hs, w_hs, ar_hs;
  logic          unused_ok;

  assign aw_hs = S_AXI_AWVALID & awready;
  assign w_hs  = S_AXI_WVALID  & wready;
  assign ar_hs = S_AXI_ARVALID & arready;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

  // Commit source: whichever half arrives last comes straight from the bus,
  // the other half from the holding registers.
  always_comb begin
    wr_en   = 1'b0;
    wr_sel  = wr_addr_q;
    wr_data = wr_data_q;
    wr_strb = wr_strb_q;
    case (w_state)
      W_IDLE: if (aw_hs && w_hs) begin
        wr_en   = 1'b1;
        wr_sel  = S_AXI_AWADDR[3:2];
        wr_data = S_AXI_WDATA[31:0];
        wr_strb = S_AXI_WSTRB[3:0];
      end
      W_HAVE_ADDR: if (w_hs) begin
        wr_en   = 1'b1;
        wr_data = S_AXI_WDATA[31:0];
        wr_strb = S_AXI_WSTRB[3:0];
      end
      W_HAVE_DATA: if (aw_hs) begin
        wr_en  = 1'b1;
        wr_sel = S_AXI_AWADDR[3:2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state   <= W_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= 2'b00;
      wr_addr_q <= 2'd0;
      wr_data_q <= 32'h0;
      wr_strb_q <= 4'h0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs && !w_hs) begin
            wr_addr_q <= S_AXI_AWADDR[3:2];
            awready   <= 1'b0;
            wready    <= 1'b1;
            w_state   <= W_HAVE_ADDR;
          end else if (w_hs && !aw_hs) begin
            wr_data_q <= S_AXI_WDATA[31:0];
            wr_strb_q <= S_AXI_WSTRB[3:0];
            awready   <= 1'b1;
            wready    <= 1'b0;
            w_state   <= W_HAVE_DATA;
          end else begin
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        W_HAVE_ADDR, W_HAVE_DATA: ;
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
      // Commit overrides the per-state defaults above.
      if (wr_en) begin
        bvalid  <= 1'b1;
        bresp   <= (wr_sel == A_IN) ? 2'b10 : 2'b00;
        awready <= 1'b0;
        wready  <= 1'b0;
        w_state <= W_RESP;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      reg_out <= PIN_OUT_RESET & PIN_MASK;
      reg_oe  <= 32'h0;
      reg_scr <= 32'h0;
    end else if (wr_en) begin
      case (wr_sel)
        A_OUT:   reg_out <= merge_bytes(reg_out, wr_data, wr_strb) & PIN_MASK;
        A_OE:    reg_oe  <= merge_bytes(reg_oe,  wr_data, wr_strb) & PIN_MASK;
        A_SCR:   reg_scr <= merge_bytes(reg_scr, wr_data, wr_strb);
        default: ;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_i;
      sync2 <= sync1;
    end
  end

  always_comb begin
    pin_in_ext = 32'h0;
    pin_in_ext[NUM_PINS-1:0] = sync2;
  end

  always_comb begin
    rd_mux = 32'h0;
    case (S_AXI_ARADDR[3:2])
      A_OUT:   rd_mux = reg_out;
      A_OE:    rd_mux = reg_oe;
      A_IN:    rd_mux = pin_in_ext;
      A_SCR:   rd_mux = reg_scr;
      default: rd_mux = 32'h0;
    endcase
  end

  // rd_mux samples pre-edge register values, so a write committing on the
  // AR handshake edge is not seen by that read.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rdata   <= rd_mux;
            rvalid  <= 1'b1;
            arready <= 1'b0;
            r_state <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign pin_o         = reg_out[NUM_PINS-1:0];
  assign pin_oe        = reg_oe[NUM_PINS-1:0];

endmodule

// File: tb/tb_pin_ctrl_axil_slave.sv
// tb_pin_ctrl_axil_slave
//   Directed bench for pin_ctrl_axil_slave: reset values, register map,
//   byte strobes, split AW/W ordering, backpressure, same-edge read/write
//   ordering and the pin input synchronizer delay.

module tb_pin_ctrl_axil_slave;

  localparam logic [31:0] OUT_RST = 32'h0000_00F0;

  logic        clk;
  logic        rst;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] rdata;
  logic [31:0] pin_i, pin_o, pin_oe;

  int n_tests = 0;
  int n_fail  = 0;

  pin_ctrl_axil_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .NUM_PINS           (32),
    .PIN_OUT_RESET      (OUT_RST)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .pin_i         (pin_i),
    .pin_o         (pin_o),
    .pin_oe        (pin_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic ok, got;
    ok = 1'b0; got = 1'b0; resp = 2'b11;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ok = awready & wready;
      @(posedge clk); #1;
      if (ok) break;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) chk("wr_hs_timeout", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) begin
        got = 1'b1; resp = bresp; bready = 1'b1;
        @(posedge clk); #1; bready = 1'b0;
        break;
      end
    end
    if (!got) chk("wr_b_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    logic ok, got;
    ok = 1'b0; got = 1'b0; data = 32'hXXXX_XXXX;
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ok = arready;
      @(posedge clk); #1;
      if (ok) break;
    end
    arvalid = 1'b0;
    if (!ok) chk("rd_hs_timeout", {31'd0, ok}, 32'd1);
    chk("rd_latency", {31'd0, rvalid}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) begin
        got = 1'b1; data = rdata; rready = 1'b1;
        chk("rd_rresp", {30'd0, rresp}, 32'd0);
        @(posedge clk); #1; rready = 1'b0;
        break;
      end
    end
    if (!got) chk("rd_r_timeout", {31'd0, got}, 32'd1);
  endtask

  // One channel first, a 3-cycle gap, then the other channel.
  task automatic write_split(input logic [3:0] addr, input logic [31:0] data, input logic aw_first);
    logic ok;
    awaddr = addr; wdata = data; wstrb = 4'hF;
    ok = 1'b0;
    if (aw_first) awvalid = 1'b1; else wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ok = aw_first ? awready : wready;
      @(posedge clk); #1;
      if (ok) break;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) chk("split_hs1_timeout", {31'd0, ok}, 32'd1);
    chk("split_first_rdy", {31'd0, aw_first ? awready : wready}, 32'd0);
    chk("split_other_rdy", {31'd0, aw_first ? wready : awready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("split_no_commit", {31'd0, bvalid}, 32'd0);
    ok = 1'b0;
    if (aw_first) wvalid = 1'b1; else awvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ok = aw_first ? wready : awready;
      @(posedge clk); #1;
      if (ok) break;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) chk("split_hs2_timeout", {31'd0, ok}, 32'd1);
    chk("split_bvalid", {31'd0, bvalid}, 32'd1);
    chk("split_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1;
    @(posedge clk); #1; bready = 1'b0;
    chk("split_b_done", {31'd0, bvalid}, 32'd0);
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    wdata = '0; wstrb = '0; pin_i = '0;

    // Reset
    repeat (5) @(posedge clk);
    #1;
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdy",    {29'd0, awready, wready, arready}, 32'd0);
    chk("rst_rdata",  rdata, 32'd0);
    chk("rst_pin_oe", pin_oe, 32'd0);
    chk("rst_pin_o",  pin_o, OUT_RST);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rdy", {29'd0, awready, wready, arready}, 32'd7);

    // Register map
    pin_i = 32'hCAFE_0001;
    repeat (3) @(posedge clk);
    #1;
    axi_write(4'h0, 32'd1, 4'hF, resp); chk("bresp_out", {30'd0, resp}, 32'd0);
    axi_write(4'h4, 32'd2, 4'hF, resp); chk("bresp_oe",  {30'd0, resp}, 32'd0);
    axi_write(4'h8, 32'd3, 4'hF, resp); chk("bresp_in",  {30'd0, resp}, 32'd2);
    axi_write(4'hC, 32'd4, 4'hF, resp); chk("bresp_scr", {30'd0, resp}, 32'd0);
    axi_read(4'h0, rd); chk("rd_out", rd, 32'd1);
    axi_read(4'h4, rd); chk("rd_oe",  rd, 32'd2);
    axi_read(4'h8, rd); chk("rd_in",  rd, 32'hCAFE_0001);
    axi_read(4'hC, rd); chk("rd_scr", rd, 32'd4);
    chk("pin_o_val",  pin_o,  32'd1);
    chk("pin_oe_val", pin_oe, 32'd2);

    // Byte strobes
    axi_write(4'hC, 32'h1122_3344, 4'hF, resp);
    axi_write(4'hC, 32'hAABB_CCDD, 4'b0010, resp);
    axi_read(4'hC, rd); chk("strb_merge", rd, 32'h1122_CC44);

    // Split AW/W ordering
    write_split(4'hC, 32'h0BAD_F00D, 1'b1);
    axi_read(4'hC, rd); chk("split_aw_data", rd, 32'h0BAD_F00D);
    write_split(4'h4, 32'h0000_00FF, 1'b0);
    chk("split_w_pin_oe", pin_oe, 32'h0000_00FF);
    axi_read(4'h4, rd); chk("split_w_data", rd, 32'h0000_00FF);

    // Backpressure: one write and one read outstanding, new requests held off
    awaddr = 4'hC; wdata = 32'h1234_5678; wstrb = 4'hF; araddr = 4'h4;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    chk("bp_rdy_in", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk); #1;
    wdata = 32'hDEAD_0000; awaddr = 4'hC; araddr = 4'h0;
    repeat (10) begin
      @(negedge clk);
      chk("bp_b",     {29'd0, bvalid, bresp}, 32'd4);
      chk("bp_r",     {29'd0, rvalid, rresp}, 32'd4);
      chk("bp_rdata", rdata, 32'h0000_00FF);
      chk("bp_rdy",   {29'd0, awready, wready, arready}, 32'd0);
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    chk("bp_release", {30'd0, bvalid, rvalid}, 32'd0);
    axi_read(4'hC, rd); chk("bp_single_commit", rd, 32'h1234_5678);

    // Same-edge read and write of SCRATCH
    axi_write(4'hC, 32'd5, 4'hF, resp);
    awaddr = 4'hC; wdata = 32'd9; wstrb = 4'hF; araddr = 4'hC;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    chk("same_rdy", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("same_valids", {30'd0, bvalid, rvalid}, 32'd3);
    chk("same_old_data", rdata, 32'd5);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    axi_read(4'hC, rd); chk("same_new_data", rd, 32'd9);

    // Synchronizer: pin_i changes after edge 0; AR handshake at edge 2 still
    // sees the old value, at edge 3 the new one.
    pin_i = 32'h5555_AAAA;
    @(posedge clk); #1;
    axi_read(4'h8, rd); chk("sync_edge2_old", rd, 32'hCAFE_0001);
    repeat (3) @(posedge clk);
    #1;
    pin_i = 32'h0F0F_1234;
    @(posedge clk);
    @(posedge clk); #1;
    axi_read(4'h8, rd); chk("sync_edge3_new", rd, 32'h0F0F_1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pin_ctrl_axil_slave.md
Name: pin_ctrl_axil_slave

Overview:
- AXI4-Lite responder that implements the pin-control register bank: output value, output enable, synchronized input sample and a scratch register.
- It sits behind the AXI interconnect as the S00_AXI endpoint and is driven by the PS or by the VIP master in simulation.
- It drives the tri-state control of up to 32 GPIO pins and samples their inputs.

Parameters:
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte-address width; bits [3:2] select the register, all other bits are ignored.
- NUM_PINS, 32: number of pins controlled (1..32); register bits at and above NUM_PINS read 0 and are not stored.
- PIN_OUT_RESET, 32'h0: reset value of PIN_OUT.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1
- S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1
- S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2
- S_AXI_BVALID  out  1
- S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1
- S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32
- S_AXI_RRESP  out  2
- S_AXI_RVALID  out  1
- S_AXI_RREADY  in  1
- pin_i  in  NUM_PINS  asynchronous pad inputs.
- pin_o  out  NUM_PINS  pad output values; equals PIN_OUT.
- pin_oe  out  NUM_PINS  pad output enables; 1 = drive; equals PIN_OE.

Behaviour:
- Clocking and reset: one clock, S_AXI_ACLK. S_AXI_ARESET is synchronous and active-high.
- Register map:
  - 0x0 PIN_OUT: R/W.
  - 0x4 PIN_OE: R/W, reset 0.
  - 0x8 PIN_IN: read-only, returns the 2-flop-synchronized pin_i.
  - 0xC SCRATCH: R/W, reset 0.
- Reset values while S_AXI_ARESET is high on a clock edge:
  - AWREADY=1, WREADY=1, ARREADY=1 (asserted in the first cycle after reset deasserts; 0 during reset).
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - PIN_OUT=PIN_OUT_RESET, PIN_OE=0, SCRATCH=0, synchronizer flops=0.
- Reset mid-transaction: any outstanding transaction is abandoned; no response is issued.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: AWREADY=WREADY=1.
  - AW and W handshake in the same cycle: the register updates at that edge; go to W_RESP.
  - AW only: latch the address; go to W_HAVE_ADDR with AWREADY=0, WREADY=1.
  - W only: latch data and strobe; go to W_HAVE_DATA with WREADY=0, AWREADY=1.
  - W_HAVE_ADDR / W_HAVE_DATA: on the missing handshake, commit the write at that edge; go to W_RESP.
  - W_RESP: BVALID=1 starting the cycle after the commit; AWREADY=WREADY=0.
  - BVALID stays high and BRESP stays stable until BREADY; then return to W_IDLE. Throughput is one write per 2 cycles minimum.
- Write commit:
  - Per byte lane, register byte k updates only if WSTRB[k]=1.
  - Write to PIN_IN: no state change, BRESP=2'b10 (SLVERR).
  - All other writes: BRESP=2'b00.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On the AR handshake, RDATA is loaded at that same edge from the current register values. A write committing on the same edge is not visible to that read. Go to R_DATA.
  - R_DATA: ARREADY=0, RVALID=1. RDATA/RRESP are held stable until RREADY; then return to R_IDLE. Read latency is 1 cycle from the AR handshake to RVALID.
  - RRESP is always 2'b00.
- Concurrency: read and write paths are fully independent and may run concurrently.
- Pin path: pin_i passes through 2 flops, so PIN_IN reflects a pin_i change after 2 edges. pin_o and pin_oe are registered, so a commit at edge N is visible after edge N.

Test Plan:
- Reset: hold S_AXI_ARESET 5 cycles -> all VALIDs 0, pin_oe=0, pin_o=PIN_OUT_RESET; AWREADY/WREADY/ARREADY=1 in the first cycle after release.
- Sequential writes of 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC, then reads:
  - BRESP = 0, 0, 2, 0.
  - Reads return 1, 2, sync(pin_i), 4.
  - pin_o=1, pin_oe=2.
- WSTRB=4'b0010 write of 0xAABBCCDD to SCRATCH (preset 0x11223344) -> readback 0x1122CC44.
- AW presented 3 cycles before W, and separately W 3 cycles before AW -> single commit, BVALID exactly 1 cycle after the second handshake, correct data.
- Backpressure: BREADY and RREADY held low 10 cycles -> BVALID/RVALID, BRESP/RDATA stable; no new AW/W/AR accepted.
- Same-edge AR handshake and write to SCRATCH (old 5, new 9) -> read returns 5, subsequent read returns 9; pin_i toggle -> PIN_IN changes after exactly 2 edges.
